// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the sizing rule for the bit counter.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter has to reach WIDTH-1, and it is never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: the team half subtractor extended with a borrow-in.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller. A single full_sub_cell is reused over
// WIDTH clock cycles, LSB first, to form diff = a - b.
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh, d_sh_nxt;
  logic [CW-1:0]    cnt;
  logic             bw;
  logic             d, bout;
  logic             load, step, finish;

  full_sub_cell u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (bw),
    .d    (d),
    .bout (bout)
  );

  // New result bit enters at the MSB, so after WIDTH shifts bit i sits at i.
  always_comb begin
    d_sh_nxt            = d_sh >> 1;
    d_sh_nxt[WIDTH-1]   = d;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == LAST) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      d_sh       <= '0;
      cnt        <= '0;
      bw         <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (load) begin
      a_sh <= a;
      b_sh <= b;
      d_sh <= '0;
      cnt  <= '0;
      bw   <= 1'b0;
    end else if (step) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      d_sh <= d_sh_nxt;
      bw   <= bout;
      cnt  <= finish ? '0 : cnt + 1'b1;
      // The result registers move only on the last bit, so they stay stable
      // throughout the following operation's RUN phase.
      if (finish) begin
        diff       <= d_sh_nxt;
        borrow_out <= bout;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8 and WIDTH=1 instances)
// against an arithmetic reference model.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bo8;
  logic [7:0] diff8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, bo1;
  logic [0:0] diff1;

  int vectors = 0;
  int errors  = 0;

  // Expected result of the most recently completed WIDTH=8 operation.
  logic [7:0] last_diff = '0;
  logic       last_bo   = 1'b0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
  );

  // Reference: {borrow, diff} from plain modular arithmetic on w-bit operands.
  function automatic logic [8:0] ref_sub(input int unsigned a, input int unsigned b,
                                         input int w);
    int unsigned m  = (32'd1 << w) - 1;
    int unsigned am = a & m;
    int unsigned bm = b & m;
    logic [8:0]  r;
    r[7:0] = 8'((am - bm) & m);
    r[8]   = (am < bm);
    return r;
  endfunction

  // Caller is at posedge+1 with the DUT idle; returns at start edge +1.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen (bounded).
  task automatic wait_done8(output int n);
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic settle;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #3;
    vectors++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b want 0", busy8); end
    vectors++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done8: got %b want 0", done8); end
    vectors++; if (diff8 !== 8'h00) begin errors++; $display("FAIL reset_diff8: got %h want 00", diff8); end
    vectors++; if (bo8 !== 1'b0) begin errors++; $display("FAIL reset_bo8: got %b want 0", bo8); end
    vectors++; if ({busy1, done1, diff1, bo1} !== 4'b0) begin errors++; $display("FAIL reset_dut1: got %b want 0000", {busy1, done1, diff1, bo1}); end
    @(negedge clk); rst = 1'b0;
    settle;
    vectors++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_idle_busy8: got %b want 0", busy8); end
  endtask

  task automatic test_basic;
    logic [8:0] r;
    r = ref_sub(8'h5A, 8'h3C, 8);
    launch8(8'h5A, 8'h3C);
    vectors++; if (busy8 !== 1'b1) begin errors++; $display("FAIL basic_busy_n0: got %b want 1", busy8); end
    vectors++; if (done8 !== 1'b0) begin errors++; $display("FAIL basic_done_n0: got %b want 0", done8); end
    for (int n = 1; n <= 8; n++) begin
      settle;
      vectors++; if (busy8 !== 1'b1) begin errors++; $display("FAIL basic_busy n=%0d: got %b want 1", n, busy8); end
      vectors++; if (done8 !== (n == 8)) begin errors++; $display("FAIL basic_done n=%0d: got %b want %b", n, done8, (n == 8)); end
      if (n < 8) begin
        vectors++; if (diff8 !== last_diff) begin errors++; $display("FAIL basic_hold n=%0d: got %h want %h", n, diff8, last_diff); end
      end
    end
    vectors++; if (diff8 !== r[7:0]) begin errors++; $display("FAIL basic_diff: got %h want %h", diff8, r[7:0]); end
    vectors++; if (bo8 !== r[8]) begin errors++; $display("FAIL basic_borrow: got %b want %b", bo8, r[8]); end
    last_diff = r[7:0]; last_bo = r[8];
    settle;
    vectors++; if ({busy8, done8} !== 2'b00) begin errors++; $display("FAIL basic_end: got busy/done %b want 00", {busy8, done8}); end
  endtask

  task automatic test_directed;
    logic [7:0] ta [3] = '{8'h03, 8'hFF, 8'h00};
    logic [7:0] tb [3] = '{8'h05, 8'hFF, 8'h01};
    logic [8:0] r;
    int         n;
    for (int i = 0; i < 3; i++) begin
      r = ref_sub(ta[i], tb[i], 8);
      launch8(ta[i], tb[i]);
      wait_done8(n);
      vectors++; if (n !== 8) begin errors++; $display("FAIL dir%0d_latency: got %0d want 8", i, n); end
      vectors++; if (diff8 !== r[7:0]) begin errors++; $display("FAIL dir%0d_diff: got %h want %h", i, diff8, r[7:0]); end
      vectors++; if (bo8 !== r[8]) begin errors++; $display("FAIL dir%0d_borrow: got %b want %b", i, bo8, r[8]); end
      last_diff = r[7:0]; last_bo = r[8];
      settle;
    end
  endtask

  task automatic test_ignore_start;
    logic [8:0] r;
    int         dones = 0;
    r = ref_sub(8'h10, 8'h01, 8);
    launch8(8'h10, 8'h01);
    for (int n = 1; n <= 12; n++) begin
      if (n == 3) begin
        start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
      end else if (n == 4) begin
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      end
      settle;
      if (done8 === 1'b1) dones++;
      if (n < 8) begin
        vectors++; if ({bo8, diff8} !== {last_bo, last_diff}) begin errors++; $display("FAIL ign_hold n=%0d: got %b/%h want %b/%h", n, bo8, diff8, last_bo, last_diff); end
      end else if (n == 8) begin
        vectors++; if (diff8 !== r[7:0]) begin errors++; $display("FAIL ign_diff: got %h want %h", diff8, r[7:0]); end
        vectors++; if (bo8 !== r[8]) begin errors++; $display("FAIL ign_borrow: got %b want %b", bo8, r[8]); end
      end
    end
    vectors++; if (dones !== 1) begin errors++; $display("FAIL ign_done_count: got %0d want 1", dones); end
    vectors++; if (busy8 !== 1'b0) begin errors++; $display("FAIL ign_idle: got busy %b want 0", busy8); end
    last_diff = r[7:0]; last_bo = r[8];
  endtask

  task automatic test_back_to_back;
    logic [8:0] r;
    int         dones = 0, last_n = -1, guard = 0;
    logic       prev_done = 1'b0;
    r = ref_sub(8'h80, 8'h7F, 8);
    a8 = 8'h80; b8 = 8'h7F; start8 = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      settle;
      if (done8 === 1'b1) begin
        dones++;
        vectors++; if (prev_done === 1'b1) begin errors++; $display("FAIL b2b_consecutive n=%0d: got done twice want once", n); end
        vectors++; if ({bo8, diff8} !== r) begin errors++; $display("FAIL b2b_result n=%0d: got %b/%h want %b/%h", n, bo8, diff8, r[8], r[7:0]); end
        if (last_n >= 0) begin
          vectors++; if (n - last_n !== 10) begin errors++; $display("FAIL b2b_period n=%0d: got %0d want 10", n, n - last_n); end
        end
        last_n = n;
      end
      prev_done = done8;
    end
    start8 = 1'b0;
    while (busy8 === 1'b1 && guard < 20) begin settle; guard++; end
    vectors++; if (dones !== 4) begin errors++; $display("FAIL b2b_done_count: got %0d want 4", dones); end
    vectors++; if (busy8 !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy %b want 0", busy8); end
    last_diff = r[7:0]; last_bo = r[8];
  endtask

  task automatic test_async_reset;
    logic [8:0] r;
    int         n, stray = 0;
    launch8(8'($urandom), 8'($urandom));
    repeat (4) settle;
    #2 rst = 1'b1;
    #1;
    vectors++; if (busy8 !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy8); end
    vectors++; if (done8 !== 1'b0) begin errors++; $display("FAIL arst_done: got %b want 0", done8); end
    vectors++; if (diff8 !== 8'h00) begin errors++; $display("FAIL arst_diff: got %h want 00", diff8); end
    vectors++; if (bo8 !== 1'b0) begin errors++; $display("FAIL arst_borrow: got %b want 0", bo8); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      settle;
      if (done8 !== 1'b0 || busy8 !== 1'b0) stray++;
    end
    vectors++; if (stray !== 0) begin errors++; $display("FAIL arst_no_done: got %0d active cycles want 0", stray); end
    r = ref_sub(8'h22, 8'h11, 8);
    launch8(8'h22, 8'h11);
    wait_done8(n);
    vectors++; if (n !== 8) begin errors++; $display("FAIL arst_latency: got %0d want 8", n); end
    vectors++; if ({bo8, diff8} !== r) begin errors++; $display("FAIL arst_result: got %b/%h want %b/%h", bo8, diff8, r[8], r[7:0]); end
    last_diff = r[7:0]; last_bo = r[8];
    settle;
  endtask

  task automatic test_width1;
    logic [8:0] r;
    int         n;
    for (int i = 0; i < 4; i++) begin
      r = ref_sub(i >> 1, i & 1, 1);
      a1 = 1'(i >> 1); b1 = 1'(i & 1); start1 = 1'b1;
      settle;
      start1 = 1'b0;
      vectors++; if ({busy1, done1} !== 2'b10) begin errors++; $display("FAIL w1_%0d_run: got busy/done %b want 10", i, {busy1, done1}); end
      n = 0;
      while (done1 !== 1'b1 && n < 10) begin settle; n++; end
      vectors++; if (n !== 1) begin errors++; $display("FAIL w1_%0d_latency: got %0d want 1", i, n); end
      vectors++; if ({bo1, diff1} !== {r[8], r[0]}) begin errors++; $display("FAIL w1_%0d_result: got %b%b want %b%b", i, bo1, diff1, r[8], r[0]); end
      settle;
      vectors++; if ({busy1, done1} !== 2'b00) begin errors++; $display("FAIL w1_%0d_end: got busy/done %b want 00", i, {busy1, done1}); end
    end
  endtask

  task automatic test_random;
    logic [7:0] ra, rb;
    logic [8:0] r;
    int         n;
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      r  = ref_sub(ra, rb, 8);
      launch8(ra, rb);
      a8 = 8'($urandom); b8 = 8'($urandom);
      wait_done8(n);
      vectors++; if (n !== 8) begin errors++; $display("FAIL rnd%0d_latency: got %0d want 8", i, n); end
      vectors++; if ({bo8, diff8} !== r) begin errors++; $display("FAIL rnd%0d_result a=%h b=%h: got %b/%h want %b/%h", i, ra, rb, bo8, diff8, r[8], r[7:0]); end
      last_diff = r[7:0]; last_bo = r[8];
      settle;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_directed;
    test_ignore_start;
    test_back_to_back;
    test_async_reset;
    test_width1;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
